softex_denominator_acc: RTL and testbench
=========================================

// Module: softex_denominator_acc
// PURPOSE
//  Downstream consumer of the EXPU array. Accumulates strobed exponential lanes (FP, value >= 0) of a
//  softmax row vector into an unsigned fixed-point denominator. Beats arrive via valid/ready; last_i
//  closes a vector; the sum is presented on a registered result port until consumed.
// PARAMETERS
//  FPFORMAT    FPFORMAT_IN  FP format of incoming lanes (man/exp bits via fpnew_pkg)
//  N_ROWS      1            lanes per beat; must match EXPU N_ROWS
//  FRAC_BITS   DENACC_FRAC_BITS (16)  fractional bits of the fixed-point sum
//  ACC_WIDTH   DENACC_ACC_WIDTH (32)  total sum width; ACC_WIDTH > FRAC_BITS
//  TAG_TYPE    logic        sideband tag; the last beat's tag is returned with the sum
// PORTS
//  clk_i     in   1               clock
//  rst_i     in   1               asynchronous, active-high reset
//  clear_i   in   1               synchronous clear of all state
//  enable_i  in   1               global stall; 0 freezes all registers, ready_o=0
//  valid_i   in   1               input beat valid
//  ready_o   out  1               input beat accepted when valid_i&ready_o
//  strb_i    in   N_ROWS          per-lane valid; unstrobed lanes contribute 0
//  op_i      in   N_ROWS x WIDTH  FP exp values
//  last_i    in   1               beat is final of its vector
//  tag_i     in   TAG_TYPE        tag
//  valid_o   out  1               sum_o valid
//  ready_i   in   1               consumer accepts sum_o
//  sum_o     out  ACC_WIDTH       fixed-point denominator (FRAC_BITS fraction)
//  ovf_o     out  1               sum overflowed/hit Inf/NaN input (qualified by valid_o)
//  tag_o     out  TAG_TYPE        tag of last beat
//  busy_o    out  1               any pipeline stage or result register occupied
// BEHAVIOUR
//  Reset/clear: valid_o=0, sum_o=0, ovf_o=0, tag_o=0, busy_o=0, accumulator=0, first-beat flag=1.
//  Stage A (registered): per lane e=0 -> 0; e=all-ones -> lane=2^ACC_WIDTH-1, set ovf; else
//   (1.m)<<(e-bias+FRAC_BITS-MAN) (right shift if negative, truncate). Sign bit ignored. Adder tree sums lanes.
//  Stage B (accumulator): first beat of vector loads tree sum, others add; carry out sets sticky ovf.
//  Result: when stage B processes a last beat, sum/ovf/tag move to result reg next edge; valid_o=1
//   until valid_o&ready_i. Latency: last beat accepted at edge t -> valid_o high from edge t+3.
//  Accumulator and ovf restart on the beat after last; next vector overlaps a pending result.
//  Stall: if stage B holds a last beat and result reg is full and ~ready_i, stages A/B hold and
//   ready_o=0. ready_o = enable_i & ~stall. Result popped and refilled on same edge is legal.
//  Single-beat vector (valid_i&last_i on first beat): sum = that beat alone.
//  Beat with strb_i=0 is accepted, contributes 0, still honours last_i.
//  enable_i=0: no state changes, valid_o held. clear_i wins over every other event same cycle.
//  Reset mid-vector: partial sum discarded, no result emitted.
// CONFIGURATION
//  SOFTEX_DENACC_SATURATE_EN defined: on overflow sum clamps to 2^ACC_WIDTH-1 and stays there for
//   the rest of the vector; ovf_o=1. Undefined: sum wraps modulo 2^ACC_WIDTH; ovf_o=1 still reported.
// STRUCTURE
//  softex_pkg: DENACC_FRAC_BITS, DENACC_ACC_WIDTH defaults; typedef denacc_result_t {sum, ovf, tag-free}.
//  Sub-module softex_fp2fixed: one lane FP->fixed conversion with Inf/NaN flag; instantiated N_ROWS times.
//  Adder tree and control (handshake, first-beat flag, stall) stay in this module.
// TESTING
//  N_ROWS=4 bf16, 1 beat op=4x0x3F80 strb=F last=1 -> sum_o=0x0004_0000, ovf_o=0, 3 cycles later.
//  2 beats 4x0x3F00 then 4x0x3E80, strb=F,3 -> sum_o=0x0002_8000 (2.0+0.5), tag_o=2nd tag.
//  ready_i=0 with result pending, two further vectors streamed -> ready_o drops, no loss, order kept.
//  Lane 0x7F80 (Inf) -> ovf_o=1; with SATURATE_EN sum_o=0xFFFF_FFFF, without, wrapped value.
//  Denorm/zero lanes (0x0001, 0x0000) and strb=0 beats -> contribute 0, last honoured.
//  clear_i mid-vector and rst_i asserted mid-vector -> next vector sum excludes prior beats.

Source files
------------

// File: rtl/softex_pkg.sv
// Shared constants and types for the softmax denominator accumulator slice.
// Default lane format is bf16 (8 exponent bits, 7 mantissa bits).
package softex_pkg;

   localparam int unsigned FP_EXP_BITS_IN   = 8;
   localparam int unsigned FP_MAN_BITS_IN   = 7;
   localparam int unsigned DENACC_FRAC_BITS = 16;
   localparam int unsigned DENACC_ACC_WIDTH = 32;

   typedef struct packed {
      logic [DENACC_ACC_WIDTH-1:0] sum;
      logic                        ovf;
   } denacc_result_t;

endpackage

// File: rtl/softex_fp2fixed.sv
// One-lane conversion of a non-negative FP magnitude (sign stripped) to unsigned fixed point.
// Zero/denormal exponents map to 0; Inf/NaN or out-of-range values clamp to all-ones and raise ovf_o.
module softex_fp2fixed
   import softex_pkg::*;
#(
   parameter int unsigned EXP_BITS  = FP_EXP_BITS_IN,
   parameter int unsigned MAN_BITS  = FP_MAN_BITS_IN,
   parameter int unsigned FRAC_BITS = DENACC_FRAC_BITS,
   parameter int unsigned ACC_WIDTH = DENACC_ACC_WIDTH
) (
   input  logic [EXP_BITS+MAN_BITS-1:0] mag_i,
   output logic [ACC_WIDTH-1:0]         val_o,
   output logic                         ovf_o
);

   localparam int BIAS    = (1 << (EXP_BITS - 1)) - 1;
   localparam int MAX_LSH = int'(ACC_WIDTH) - int'(MAN_BITS) - 1;

   logic [EXP_BITS-1:0]  exp_f;
   logic [MAN_BITS-1:0]  man_f;
   logic [ACC_WIDTH-1:0] mant_ext;
   int                   sh;

   assign exp_f    = mag_i[EXP_BITS+MAN_BITS-1:MAN_BITS];
   assign man_f    = mag_i[MAN_BITS-1:0];
   assign mant_ext = ACC_WIDTH'({1'b1, man_f});

   always_comb begin
      val_o = '0;
      ovf_o = 1'b0;
      sh    = int'(exp_f) - BIAS + int'(FRAC_BITS) - int'(MAN_BITS);
      if (exp_f == '0) begin
         val_o = '0;
      end else if (exp_f == '1 || sh > MAX_LSH) begin
         val_o = '1;
         ovf_o = 1'b1;
      end else if (sh >= 0) begin
         val_o = mant_ext << sh;
      end else begin
         val_o = mant_ext >> (-sh);
      end
   end

endmodule

// File: rtl/softex_denominator_acc.sv
// Accumulates strobed FP exponential lanes of a softmax row into a fixed-point denominator.
// Define SOFTEX_DENACC_SATURATE_EN to clamp the sum on overflow instead of wrapping.
module softex_denominator_acc
   import softex_pkg::*;
#(
   parameter int unsigned EXP_BITS  = FP_EXP_BITS_IN,
   parameter int unsigned MAN_BITS  = FP_MAN_BITS_IN,
   parameter int unsigned N_ROWS    = 1,
   parameter int unsigned FRAC_BITS = DENACC_FRAC_BITS,
   parameter int unsigned ACC_WIDTH = DENACC_ACC_WIDTH,
   parameter type         TAG_TYPE  = logic
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    clear_i,
   input  logic                                    enable_i,
   input  logic                                    valid_i,
   output logic                                    ready_o,
   input  logic [N_ROWS-1:0]                       strb_i,
   input  logic [N_ROWS-1:0][EXP_BITS+MAN_BITS:0]  op_i,
   input  logic                                    last_i,
   input  TAG_TYPE                                 tag_i,
   output logic                                    valid_o,
   input  logic                                    ready_i,
   output logic [ACC_WIDTH-1:0]                    sum_o,
   output logic                                    ovf_o,
   output TAG_TYPE                                 tag_o,
   output logic                                    busy_o
);

   localparam int unsigned TREE_W = ACC_WIDTH + $clog2(N_ROWS);

   // a1: converted lanes, a2: adder-tree sum, b: running accumulator, r: result register
   typedef struct packed {
      logic                             a1_vld;
      logic                             a1_last;
      logic                             a1_ovf;
      TAG_TYPE                          a1_tag;
      logic [N_ROWS-1:0][ACC_WIDTH-1:0] a1_lane;
      logic                             a2_vld;
      logic                             a2_last;
      logic                             a2_ovf;
      TAG_TYPE                          a2_tag;
      logic [TREE_W-1:0]                a2_sum;
      logic                             b_vld;
      logic                             b_last;
      logic                             b_ovf;
      logic                             b_first;
      TAG_TYPE                          b_tag;
      logic [ACC_WIDTH-1:0]             b_acc;
      logic                             r_vld;
      logic                             r_ovf;
      TAG_TYPE                          r_tag;
      logic [ACC_WIDTH-1:0]             r_sum;
   } state_t;

   state_t                           st_q, st_d;
   logic [N_ROWS-1:0][ACC_WIDTH-1:0] lane_fix, lane_gated;
   logic [N_ROWS-1:0]                lane_ovf;
   logic [N_ROWS-1:0]                sign_unused;
   logic                             in_ovf;
   logic [TREE_W-1:0]                tree_sum;
   logic [TREE_W:0]                  acc_sum;
   logic                             acc_ovf;
   logic [ACC_WIDTH-1:0]             acc_nxt;
   logic                             stall;

   for (genvar g = 0; g < N_ROWS; g++) begin : gen_lane
      assign sign_unused[g] = op_i[g][EXP_BITS+MAN_BITS];
      softex_fp2fixed #(
         .EXP_BITS  (EXP_BITS),
         .MAN_BITS  (MAN_BITS),
         .FRAC_BITS (FRAC_BITS),
         .ACC_WIDTH (ACC_WIDTH)
      ) i_fp2fixed (
         .mag_i (op_i[g][EXP_BITS+MAN_BITS-1:0]),
         .val_o (lane_fix[g]),
         .ovf_o (lane_ovf[g])
      );
   end

   always_comb begin
      for (int unsigned i = 0; i < N_ROWS; i++) begin
         lane_gated[i] = strb_i[i] ? lane_fix[i] : '0;
      end
      in_ovf = |(lane_ovf & strb_i);

      tree_sum = '0;
      for (int unsigned i = 0; i < N_ROWS; i++) begin
         tree_sum = tree_sum + TREE_W'(st_q.a1_lane[i]);
      end

      // first beat of a vector discards the previous accumulator and sticky overflow
      acc_sum = (st_q.b_first ? '0 : (TREE_W+1)'(st_q.b_acc)) + (TREE_W+1)'(st_q.a2_sum);
      acc_ovf = (~st_q.b_first & st_q.b_ovf) | st_q.a2_ovf | (|acc_sum[TREE_W:ACC_WIDTH]);
`ifdef SOFTEX_DENACC_SATURATE_EN
      acc_nxt = acc_ovf ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
      acc_nxt = acc_sum[ACC_WIDTH-1:0];
`endif

      stall = st_q.b_vld & st_q.b_last & st_q.r_vld & ~ready_i;
      st_d  = st_q;

      if (enable_i) begin
         if (st_q.r_vld & ready_i) st_d.r_vld = 1'b0;
         if (!stall) begin
            if (st_q.b_vld & st_q.b_last) begin
               st_d.r_vld = 1'b1;
               st_d.r_sum = st_q.b_acc;
               st_d.r_ovf = st_q.b_ovf;
               st_d.r_tag = st_q.b_tag;
            end
            st_d.a1_vld  = valid_i;
            st_d.a1_last = last_i;
            st_d.a1_ovf  = in_ovf;
            st_d.a1_tag  = tag_i;
            st_d.a1_lane = lane_gated;
            st_d.a2_vld  = st_q.a1_vld;
            st_d.a2_last = st_q.a1_last;
            st_d.a2_ovf  = st_q.a1_ovf;
            st_d.a2_tag  = st_q.a1_tag;
            st_d.a2_sum  = tree_sum;
            st_d.b_vld   = st_q.a2_vld;
            st_d.b_last  = st_q.a2_last;
            st_d.b_tag   = st_q.a2_tag;
            if (st_q.a2_vld) begin
               st_d.b_acc   = acc_nxt;
               st_d.b_ovf   = acc_ovf;
               st_d.b_first = st_q.a2_last;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q         <= '0;
         st_q.b_first <= 1'b1;
      end else if (clear_i) begin
         st_q         <= '0;
         st_q.b_first <= 1'b1;
      end else begin
         st_q <= st_d;
      end
   end

   assign ready_o = enable_i & ~stall;
   assign valid_o = st_q.r_vld;
   assign sum_o   = st_q.r_sum;
   assign ovf_o   = st_q.r_ovf;
   assign tag_o   = st_q.r_tag;
   assign busy_o  = st_q.a1_vld | st_q.a2_vld | st_q.b_vld | st_q.r_vld;

endmodule

// File: tb/tb_softex_denominator_acc.sv
// Directed bench for softex_denominator_acc (N_ROWS=4, bf16 lanes, 8-bit tag) with a result scoreboard.
module tb_softex_denominator_acc;

   logic              clk_i = 1'b0;
   logic              rst_i, clear_i, enable_i, valid_i, last_i, ready_i;
   logic              ready_o, valid_o, ovf_o, busy_o;
   logic [3:0]        strb_i;
   logic [3:0][15:0]  op_i;
   logic [7:0]        tag_i, tag_o;
   logic [31:0]       sum_o;

   typedef struct packed {
      logic [31:0] sum;
      logic        ovf;
      logic [7:0]  tag;
   } exp_t;

   exp_t   sb[$];
   int     errors = 0;
   int     checks = 0;
   longint mdl_sum = 0;
   bit     mdl_ovf = 1'b0;
   bit     mdl_first = 1'b1;

   softex_denominator_acc #(
      .N_ROWS   (4),
      .TAG_TYPE (logic [7:0])
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .enable_i (enable_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .strb_i   (strb_i),
      .op_i     (op_i),
      .last_i   (last_i),
      .tag_i    (tag_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .sum_o    (sum_o),
      .ovf_o    (ovf_o),
      .tag_o    (tag_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   // bf16 magnitude -> Q.16 value, computed in real arithmetic
   function automatic longint lane_val(input logic [15:0] x, output bit inf);
      int  e;
      int  m;
      real v;
      e   = int'(x[14:7]);
      m   = int'(x[6:0]);
      inf = 1'b0;
      if (e == 0) return 0;
      if (e == 255) begin inf = 1'b1; return 64'hFFFF_FFFF; end
      v = (1.0 + m / 128.0) * (2.0 ** (e - 127)) * 65536.0;
      if (v >= 4294967296.0) begin inf = 1'b1; return 64'hFFFF_FFFF; end
      return longint'($floor(v));
   endfunction

   task automatic model_beat(input logic [3:0][15:0] ops, input logic [3:0] strb,
                             input logic last, input logic [7:0] tag);
      bit     inf;
      longint v;
      exp_t   e;
      if (mdl_first) begin mdl_sum = 0; mdl_ovf = 1'b0; end
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            v = lane_val(ops[i], inf);
            mdl_sum += v;
            mdl_ovf |= inf;
         end
      end
      if (mdl_sum > 64'hFFFF_FFFF) begin mdl_ovf = 1'b1; mdl_sum &= 64'hFFFF_FFFF; end
`ifdef SOFTEX_DENACC_SATURATE_EN
      if (mdl_ovf) mdl_sum = 64'hFFFF_FFFF;
`endif
      mdl_first = last;
      if (last) begin
         e.sum = mdl_sum[31:0];
         e.ovf = mdl_ovf;
         e.tag = tag;
         sb.push_back(e);
      end
   endtask

   task automatic send_beat(input logic [3:0][15:0] ops, input logic [3:0] strb,
                            input logic last, input logic [7:0] tag);
      bit          acc = 1'b0;
      int unsigned n = 0;
      op_i = ops; strb_i = strb; last_i = last; tag_i = tag; valid_i = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk_i);
         acc = ready_o;
         @(posedge clk_i);
         #1;
         n++;
      end
      valid_i = 1'b0;
      check("send_accept", 64'(acc), 64'd1);
      if (acc) model_beat(ops, strb, last, tag);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk_i);
         n++;
      end
      #1;
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && !clear_i && enable_i && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 64'(valid_o), 64'd0);
         end else begin
            e = sb.pop_front();
            check("sum", 64'(sum_o), 64'(e.sum));
            check("ovf", 64'(ovf_o), 64'(e.ovf));
            check("tag", 64'(tag_o), 64'(e.tag));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; valid_i = 1'b0; last_i = 1'b0;
      ready_i = 1'b1; strb_i = '0; op_i = '0; tag_i = '0;

      // reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_sum",   64'(sum_o),   64'd0);
      check("rst_ovf",   64'(ovf_o),   64'd0);
      check("rst_tag",   64'(tag_o),   64'd0);
      check("rst_busy",  64'(busy_o),  64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("idle_ready", 64'(ready_o), 64'd1);

      // single-beat vector: 4 x 1.0, valid_o rises exactly three edges after acceptance
      send_beat({4{16'h3F80}}, 4'hF, 1'b1, 8'h11);
      check("busy_after_accept", 64'(busy_o), 64'd1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk_i);
         #1;
         check("latency_valid", 64'(valid_o), (k == 3) ? 64'd1 : 64'd0);
      end
      check("one_beat_sum", 64'(sum_o), 64'h0004_0000);
      check("one_beat_ovf", 64'(ovf_o), 64'd0);
      drain();

      // two beats: 4 x 0.5 then 2 strobed lanes of 0.25
      send_beat({4{16'h3F00}}, 4'hF, 1'b0, 8'h01);
      send_beat({4{16'h3E80}}, 4'h3, 1'b1, 8'h02);
      drain();
      check("two_beat_model", 64'(mdl_sum), 64'h0002_8000);

      // back-pressure: results held while three vectors stream in
      ready_i = 1'b0;
      fork
         begin
            send_beat({16'h0, 16'h0, 16'h0, 16'h3F80}, 4'h1, 1'b1, 8'hA1);
            send_beat({4{16'h3F80}}, 4'hF, 1'b0, 8'hB0);
            send_beat({4{16'h3F00}}, 4'hF, 1'b1, 8'hB1);
            send_beat({4{16'h3E80}}, 4'hF, 1'b1, 8'hC1);
            send_beat({4{16'h4000}}, 4'hF, 1'b1, 8'hC2);
         end
         begin
            repeat (12) @(posedge clk_i);
            #2;
            check("stall_ready_low", 64'(ready_o), 64'd0);
            check("stall_valid_held", 64'(valid_o), 64'd1);
            check("stall_tag_first", 64'(tag_o), 64'hA1);
            ready_i = 1'b1;
         end
      join
      drain();

      // Inf lane raises ovf; sum wraps or clamps depending on build
      send_beat({16'h0000, 16'h0000, 16'h3F80, 16'h7F80}, 4'hF, 1'b1, 8'h33);
      drain();
`ifdef SOFTEX_DENACC_SATURATE_EN
      check("inf_model_sum", 64'(mdl_sum), 64'hFFFF_FFFF);
`else
      check("inf_model_sum", 64'(mdl_sum), 64'h0000_FFFF);
`endif
      // overflow does not leak into the next vector
      send_beat({4{16'h3F80}}, 4'h1, 1'b1, 8'h34);
      drain();

      // denormal/zero lanes and empty-strobe beats contribute nothing, last still closes
      send_beat({16'h3F80, 16'h3F80, 16'h0000, 16'h0001}, 4'hF, 1'b0, 8'h60);
      send_beat({4{16'h3F80}}, 4'h0, 1'b0, 8'h61);
      send_beat({4{16'h7F80}}, 4'h0, 1'b1, 8'h66);
      drain();

      // clear mid-vector discards the partial sum
      send_beat({4{16'h3F80}}, 4'hF, 1'b0, 8'h70);
      repeat (3) @(posedge clk_i);
      #1;
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      mdl_first = 1'b1;
      check("clear_busy", 64'(busy_o), 64'd0);
      check("clear_valid", 64'(valid_o), 64'd0);
      send_beat({4{16'h3F00}}, 4'hF, 1'b1, 8'h71);
      drain();

      // asynchronous reset mid-vector
      send_beat({4{16'h4000}}, 4'hF, 1'b0, 8'h80);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      check("async_rst_busy", 64'(busy_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      mdl_first = 1'b1;
      send_beat({16'h0, 16'h0, 16'h3F80, 16'h3F80}, 4'h3, 1'b1, 8'h81);
      drain();

      // enable_i low freezes a pending result and blocks input
      ready_i = 1'b0;
      send_beat({16'h0, 16'h0, 16'h0, 16'h3F80}, 4'h1, 1'b1, 8'hE1);
      repeat (4) @(posedge clk_i);
      #1;
      check("pend_valid", 64'(valid_o), 64'd1);
      enable_i = 1'b0;
      ready_i  = 1'b1;
      #1;
      check("disabled_ready", 64'(ready_o), 64'd0);
      repeat (3) @(posedge clk_i);
      #1;
      check("disabled_valid_held", 64'(valid_o), 64'd1);
      check("disabled_tag_held", 64'(tag_o), 64'hE1);
      enable_i = 1'b1;
      drain();

      repeat (3) @(posedge clk_i);
      #1;
      check("final_idle", 64'(busy_o), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
